// File: rtl/freq_window_monitor.sv
// freq_window_monitor
//   Qualifies the 32-bit frequency word from the frequency gauge against a
//   programmable [LOW, HIGH] window. It runs a lock/loss state machine with
//   hysteresis and keeps last/min/max statistics and a saturating loss counter.
//   A maskable sticky fault drives irq. CSRs are reached over Avalon-MM with a
//   fixed read latency of 1.
//
// Ports
//   ref_clk       clock; all logic is synchronous to it
//   reset         synchronous, active-high reset
//   freq_hz       gauge result in Hz; 32'hFFFFFFFF means no valid measurement
//   mm_address    CSR word address (0 CTRL, 1 LOW, 2 HIGH, 3 STATUS,
//                 4 LAST, 5 MIN, 6 MAX, 7 LOSS)
//   mm_read       read strobe; mm_readdata is updated on the following edge
//   mm_write      write strobe
//   mm_writedata  write data
//   mm_readdata   registered read data; holds its value between reads
//   locked        1 while the state machine is LOCKED
//   irq           fault_sticky & irq_en
module freq_window_monitor #(
   parameter int unsigned SamplePeriod = 550000,
   parameter int unsigned LockCount    = 4,
   parameter int unsigned UnlockCount  = 2,
   parameter logic [31:0] DefaultLow   = 32'd0,
   parameter logic [31:0] DefaultHigh  = 32'hFFFF_FFFE
) (
   input  logic        ref_clk,
   input  logic        reset,
   input  logic [31:0] freq_hz,
   input  logic [2:0]  mm_address,
   input  logic        mm_read,
   input  logic        mm_write,
   input  logic [31:0] mm_writedata,
   output logic [31:0] mm_readdata,
   output logic        locked,
   output logic        irq
);

   localparam int TimerW = (SamplePeriod > 1) ? $clog2(SamplePeriod) : 1;
   localparam int GoodW  = $clog2(LockCount + 1);
   localparam int BadW   = $clog2(UnlockCount + 1);

   localparam logic [TimerW-1:0] TimerReload = TimerW'(SamplePeriod - 1);
   localparam logic [GoodW-1:0]  GoodMax     = GoodW'(LockCount);
   localparam logic [BadW-1:0]   BadMax      = BadW'(UnlockCount);

   localparam logic [2:0] AddrCtrl   = 3'd0;
   localparam logic [2:0] AddrLow    = 3'd1;
   localparam logic [2:0] AddrHigh   = 3'd2;
   localparam logic [2:0] AddrStatus = 3'd3;
   localparam logic [2:0] AddrLast   = 3'd4;
   localparam logic [2:0] AddrMin    = 3'd5;
   localparam logic [2:0] AddrMax    = 3'd6;
   localparam logic [2:0] AddrLoss   = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACQUIRE = 2'd1,
      S_LOCKED  = 2'd2,
      S_LOST    = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [GoodW-1:0]  good_q, good_d;
   logic [BadW-1:0]   bad_q, bad_d;
   logic [TimerW-1:0] timer_q;
   logic [31:0]       low_q, high_q, last_q, min_q, max_q;
   logic [15:0]       loss_q;
   logic              irq_en_q, fault_q;
   logic              fault_set, loss_inc;
   logic [31:0]       rdata_mux;

   logic strobe, sample_valid, in_window;
   logic wr_ctrl, wr_low, wr_high, wr_status, wr_min, wr_loss, reacquire;

   assign strobe       = (timer_q == '0);
   assign sample_valid = (freq_hz != 32'hFFFF_FFFF);
   // An inverted window (LOW > HIGH) can never satisfy both compares.
   assign in_window    = sample_valid && (freq_hz >= low_q) && (freq_hz <= high_q);

   assign wr_ctrl   = mm_write && (mm_address == AddrCtrl);
   assign wr_low    = mm_write && (mm_address == AddrLow);
   assign wr_high   = mm_write && (mm_address == AddrHigh);
   assign wr_status = mm_write && (mm_address == AddrStatus);
   assign wr_min    = mm_write && (mm_address == AddrMin);
   assign wr_loss   = mm_write && (mm_address == AddrLoss);
   assign reacquire = wr_ctrl && mm_writedata[1];

   // Next-state logic. A reacquire request overrides whatever the strobe
   // would have done, and it suppresses that strobe's fault and loss side effects.
   always_comb begin
      // NOTE: every output of this block gets a default first so that no path
      // leaves a variable unassigned, which would otherwise infer a latch.
      state_d   = state_q;
      good_d    = good_q;
      bad_d     = bad_q;
      fault_set = 1'b0;
      loss_inc  = 1'b0;
      if (reacquire) begin
         state_d = S_IDLE;
         good_d  = '0;
         bad_d   = '0;
      end else if (strobe) begin
         if (!sample_valid) begin
            state_d = S_IDLE;
            good_d  = '0;
            bad_d   = '0;
            if (state_q == S_LOCKED) begin
               fault_set = 1'b1;
               loss_inc  = 1'b1;
            end
         end else begin
            case (state_q)
               // good_q is always 0 in IDLE, so the first valid sample is
               // counted exactly as if it arrived in ACQUIRE.
               S_IDLE, S_ACQUIRE: begin
                  state_d = S_ACQUIRE;
                  if (in_window) begin
                     good_d = (good_q == GoodMax) ? GoodMax : good_q + GoodW'(1);
                     if (good_d == GoodMax) begin
                        state_d = S_LOCKED;
                        bad_d   = '0;
                     end
                  end else begin
                     good_d = '0;
                  end
               end
               S_LOCKED: begin
                  if (!in_window) begin
                     bad_d = (bad_q == BadMax) ? BadMax : bad_q + BadW'(1);
                     if (bad_d == BadMax) begin
                        state_d   = S_LOST;
                        fault_set = 1'b1;
                        loss_inc  = 1'b1;
                     end
                  end else begin
                     bad_d = '0;
                  end
               end
               S_LOST: begin
                  if (in_window) begin
                     good_d  = GoodW'(1);
                     bad_d   = '0;
                     state_d = (GoodMax == GoodW'(1)) ? S_LOCKED : S_ACQUIRE;
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge ref_clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the values that existed before this edge.
      if (reset) begin
         state_q <= S_IDLE;
         good_q  <= '0;
         bad_q   <= '0;
         locked  <= 1'b0;
      end else begin
         state_q <= state_d;
         good_q  <= good_d;
         bad_q   <= bad_d;
         locked  <= (state_d == S_LOCKED);
      end
   end

   always_ff @(posedge ref_clk) begin
      if (reset) begin
         timer_q  <= TimerReload;
         low_q    <= DefaultLow;
         high_q   <= DefaultHigh;
         irq_en_q <= 1'b0;
         fault_q  <= 1'b0;
         last_q   <= 32'hFFFF_FFFF;
         min_q    <= 32'hFFFF_FFFF;
         max_q    <= 32'd0;
         loss_q   <= 16'd0;
      end else begin
         timer_q <= strobe ? TimerReload : timer_q - TimerW'(1);
         if (wr_ctrl) irq_en_q <= mm_writedata[0];
         if (wr_low)  low_q    <= mm_writedata;
         if (wr_high) high_q   <= mm_writedata;
         if (strobe)  last_q   <= freq_hz;

         // A new fault wins over a simultaneous write-1-to-clear.
         if (fault_set)                         fault_q <= 1'b1;
         else if (wr_status && mm_writedata[8]) fault_q <= 1'b0;

         // A clear that coincides with a valid sample restarts the statistics from that sample.
         if (strobe && sample_valid) begin
            if (wr_min) begin
               min_q <= freq_hz;
               max_q <= freq_hz;
            end else begin
               if (freq_hz < min_q) min_q <= freq_hz;
               if (freq_hz > max_q) max_q <= freq_hz;
            end
         end else if (wr_min) begin
            min_q <= 32'hFFFF_FFFF;
            max_q <= 32'd0;
         end

         // A loss that coincides with a clear leaves exactly one loss counted.
         if (loss_inc) begin
            if (wr_loss)                  loss_q <= 16'd1;
            else if (loss_q != 16'hFFFF)  loss_q <= loss_q + 16'd1;
         end else if (wr_loss) begin
            loss_q <= 16'd0;
         end
      end
   end

   // Read mux. It sees the values from before any write in the same cycle.
   always_comb begin
      rdata_mux = 32'd0;
      case (mm_address)
         AddrCtrl:   rdata_mux = {31'd0, irq_en_q};
         AddrLow:    rdata_mux = low_q;
         AddrHigh:   rdata_mux = high_q;
         AddrStatus: rdata_mux = {23'd0, fault_q, 5'd0, locked, state_q};
         AddrLast:   rdata_mux = last_q;
         AddrMin:    rdata_mux = min_q;
         AddrMax:    rdata_mux = max_q;
         AddrLoss:   rdata_mux = {16'd0, loss_q};
      endcase
   end

   always_ff @(posedge ref_clk) begin
      if (reset)        mm_readdata <= 32'd0;
      else if (mm_read) mm_readdata <= rdata_mux;
   end

   assign irq = fault_q & irq_en_q;

endmodule
